// File: rtl/rom_scan_ctrl.sv
// Burst reader for the 8x4 lookup ROM: drives rom_addr, captures each word and streams it out.
// Latency: start sampled -> FETCH -> out_valid one edge later; at most 1 word per 2 cycles.
// Backpressure: a word is held in OUT (data, address and rom_addr frozen) until out_ready.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, start_addr       burst request (sampled in IDLE only) and first ROM address
//   count                   burst length 0..8, larger values clamp to 8
//   rom_addr / rom_data     registered ROM address, combinational ROM word back
//   out_valid/out_ready     output stream handshake for out_data/out_addr
//   sum                     sum of words accepted this burst, cleared on start
//   busy, done              high in FETCH/OUT; one-cycle pulse at burst end
module rom_scan_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int SUM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);

  state_t state, state_nxt;
  logic [ADDR_W:0] rem;
  logic [ADDR_W:0] count_clamped;

  assign count_clamped = (count > MAX_CNT) ? MAX_CNT : count;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (count_clamped != '0) ? FETCH : DONE;
      FETCH: state_nxt = OUT;
      // out_valid is always high in OUT, so out_ready alone completes the handshake
      OUT:   if (out_ready) state_nxt = (rem == (ADDR_W+1)'(1)) ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded straight from the state register, so they are glitch-free
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      FETCH, OUT: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // datapath: address, captured word, remaining count, running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      sum       <= '0;
      rem       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rom_addr <= start_addr;
          rem      <= count_clamped;
          sum      <= '0;
        end
        FETCH: begin
          // rom_addr has been stable for a full cycle, so rom_data is settled here
          out_data  <= rom_data;
          out_addr  <= rom_addr;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          sum       <= sum + SUM_W'(out_data);
          out_valid <= 1'b0;
          rem       <= rem - (ADDR_W+1)'(1);
          rom_addr  <= rom_addr + ADDR_W'(1);   // natural wrap 7 -> 0
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
module tb_rom_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] start_addr = '0;
  logic [3:0] count = '0;
  logic [2:0] rom_addr;
  logic [3:0] rom_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_data;
  logic [2:0] out_addr;
  logic [7:0] sum;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  // ROM contents mem[i] = 2*i
  assign rom_data = {rom_addr, 1'b0};

  always #5 clk = ~clk;

  rom_scan_ctrl #(.ADDR_W(3), .DATA_W(4), .SUM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .sum(sum), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One burst; words are checked against the mem[i]=2*i table, exp_sum is hand-computed.
  // stall_word/stall_len hold out_ready low on that word; poke raises start during the stall.
  task automatic burst(input logic [2:0] sa, input logic [3:0] cnt, input int exp_sum,
                       input int stall_word, input int stall_len, input bit poke);
    int n;
    int dones;
    int budget;
    logic [2:0] a;
    n = (cnt > 8) ? 8 : int'(cnt);
    dones = 0;
    start_addr = sa;
    count = cnt;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      chk("empty_valid", out_valid, 0);
      tick();
      chk("empty_done_off", done, 0);
      chk("empty_valid2", out_valid, 0);
      chk("empty_sum", sum, exp_sum);
      return;
    end
    chk("fetch_busy", busy, 1);
    chk("fetch_rom_addr", rom_addr, sa);
    chk("fetch_valid", out_valid, 0);
    tick();
    chk("first_valid_latency", out_valid, 1);
    for (int w = 0; w < n; w++) begin
      budget = 10;
      while (!out_valid && budget > 0) begin
        if (done) dones++;
        tick();
        budget--;
      end
      chk("wait_valid", out_valid, 1);
      a = sa + 3'(w);
      chk("out_addr", out_addr, a);
      chk("out_data", out_data, {a, 1'b0});
      chk("rom_addr_hold", rom_addr, a);
      if (w == stall_word) begin
        out_ready = 1'b0;
        if (poke) begin
          start = 1'b1;
          start_addr = sa + 3'd4;
          count = 4'd1;
        end
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, {a, 1'b0});
          chk("stall_addr", out_addr, a);
          chk("stall_rom_addr", rom_addr, a);
        end
        out_ready = 1'b1;
      end
      tick();
      start = 1'b0;
      count = cnt;
      chk("valid_drop", out_valid, 0);
      if (done) dones++;
    end
    chk("sum_final", sum, exp_sum);
    chk("busy_at_end", busy, 0);
    tick();
    if (done) dones++;
    chk("done_pulses", dones, 1);
    chk("sum_hold", sum, exp_sum);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_sum", sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: full burst from 0, sum 0+2+..+14 = 56
    burst(3'd0, 4'd8, 56, -1, 0, 1'b0);
    // 2: wrap 6,7,0,1 -> 12+14+0+2 = 28
    burst(3'd6, 4'd4, 28, -1, 0, 1'b0);
    // 3: stall 5 cycles on word 2 (addr 2): 2+4+6 = 12
    burst(3'd1, 4'd3, 12, 1, 5, 1'b0);
    // 4: empty burst, then count=12 clamps to 8 (all words) = 56
    burst(3'd5, 4'd0, 0, -1, 0, 1'b0);
    burst(3'd3, 4'd12, 56, -1, 0, 1'b0);
    // 5: start during busy ignored: addrs 2,3 -> 4+6 = 10
    burst(3'd2, 4'd2, 10, 0, 3, 1'b1);

    // reset mid-OUT
    start_addr = 3'd4;
    count = 4'd3;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_data", out_data, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sum", sum, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", busy, 0);
    // after reset: 5,6 -> 10+12 = 22
    burst(3'd5, 4'd2, 22, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
